buf_wr_port_arbiter: RTL and testbench
======================================

# buf_wr_port_arbiter

Shares the single namespace-buffer write port between two sources: the SIMD execute control pipeline and the load/store unit.
- The execute pipeline has no backpressure, so its writes are absorbed by a small FIFO and take priority.
- The load/store unit uses a valid/ready handshake and has a starvation guard.
- The granted write is driven onto a registered write port that feeds the buffer banks.

## Interface
- NS_ID_BITS, 3, namespace ID width
- NS_INDEX_ID_BITS, 5, namespace index width
- BASE_STRIDE_WIDTH, 4*(NS_INDEX_ID_BITS+NS_ID_BITS), write address width
- DATA_WIDTH, 32, write data width
- FIFO_DEPTH, 4, execute-side FIFO entries; power of two, 2..16
- STARVE_LIMIT, 3, consecutive denied load/store cycles before a forced load/store grant; 1..15
- clk  in  1  clock; all state on rising edge
- reset  in  1  asynchronous, active-high reset
- exec_wr_req  in  6  execute write-request vector; nonzero = push this cycle
- exec_wr_addr  in  BASE_STRIDE_WIDTH  execute write address
- exec_wr_data  in  DATA_WIDTH  execute write data
- ls_valid  in  1  load/store request valid
- ls_ready  out  1  load/store request accepted (combinational)
- ls_wr_req  in  6  load/store write-request vector
- ls_wr_addr  in  BASE_STRIDE_WIDTH  load/store write address
- ls_wr_data  in  DATA_WIDTH  load/store write data
- clr_ovf  in  1  synchronous clear of ovf
- buf_wr_req_out  out  6  registered write-request vector to buffers
- buf_wr_addr_out  out  BASE_STRIDE_WIDTH  registered write address
- buf_wr_data_out  out  DATA_WIDTH  registered write data
- buf_wr_src  out  1  source of the current output: 0 = execute, 1 = load/store
- fifo_count  out  $clog2(FIFO_DEPTH)+1  execute FIFO occupancy
- ovf  out  1  sticky execute-FIFO overflow flag

## Operation
- **Execute push.** When exec_wr_req != 0, the entry {req, addr, data} is written to the FIFO tail at the clock edge.
  - If the FIFO is full and no pop happens that cycle, the entry is dropped and ovf sets.
  - If the FIFO is full and a pop happens the same cycle, the push succeeds with no overflow.
- **Candidates.** E is valid when the FIFO is non-empty (head entry). L is valid when ls_valid=1.
- **Arbitration.** A forced load/store grant occurs when starve_cnt == STARVE_LIMIT.
  - Grant E if E is valid and no forced load/store grant is due.
  - Otherwise grant L if L is valid.
  - Otherwise there is no grant.
- **ls_ready.** ls_ready = FIFO empty OR starve_cnt == STARVE_LIMIT. It does not depend on ls_valid. A handshake is ls_valid & ls_ready.
- **starve_cnt** (4-bit, saturating at STARVE_LIMIT):
  - +1 when ls_valid & !ls_ready.
  - Cleared on a handshake or when ls_valid=0.
- **Zero-vector load/store request.** A handshake with ls_wr_req == 0 is consumed and produces an idle output cycle (outputs zero, src=1).
- **Output register update at each edge:**
  - Execute grant: head fields, src=0, FIFO pops.
  - Load/store grant: ls fields, src=1.
  - No grant: req/addr/data = 0, src holds.
- **Entry order.** FIFO entries leave strictly in push order. Pointers wrap modulo FIFO_DEPTH. fifo_count is exact from 0 to FIFO_DEPTH.
- **ovf.** Sets on a drop and clears on clr_ovf. If both occur in the same cycle, set wins.
- **Reset (any time, including mid-burst):**
  - FIFO is flushed: pointers and count go to 0.
  - starve_cnt=0, ovf=0.
  - All outputs go to 0, including src.
  - Any in-flight load/store request not yet handshaked is not accepted.

## Timing
- **Execute latency.** A push at edge t becomes the head at t+1 if the FIFO was empty. The earliest grant is cycle t+1, with the output visible after edge t+1, i.e. 2 cycles push-to-port.
- **Load/store latency.** A handshake in cycle t gives the output visible after edge t, i.e. 1 cycle.
- **Throughput.** One write per cycle on the port.
- **Execute backlog.** A continuous execute stream can hold the FIFO non-empty indefinitely. Load/store still gets one grant every STARVE_LIMIT+1 cycles while valid.
- **Push during forced grant.** A push in the same cycle as a forced load/store grant is still accepted if there is space.
- **Output hold.** Outputs are valid for exactly one cycle per grant. The port is idle (req=0) on non-grant cycles.

## Test plan
- **Execute-only burst.**
  - Stimulus: exec pushes req=6'b000001 with addr=0..3 on 4 consecutive cycles, ls_valid=0.
  - Required: buf_wr_addr_out=0,1,2,3 on cycles 2..5, src=0; fifo_count peaks at 1; ovf=0.
- **Starvation guard.**
  - Stimulus: STARVE_LIMIT=3, exec pushes every cycle, ls_valid=1 held.
  - Required: ls_ready rises on the 4th cycle of ls_valid; one load/store write (src=1) appears; starve_cnt returns to 0; the execute entries then drain in order with none lost.
- **Overflow.**
  - Stimulus: ls_valid=1 with starve_cnt forced (STARVE_LIMIT=1) while 6 execute pushes arrive back-to-back with FIFO_DEPTH=4.
  - Required: ovf=1 after the first push that finds the FIFO full with no pop; fifo_count never exceeds 4; clr_ovf then clears ovf.
- **Simultaneous push and pop at full.**
  - Stimulus: FIFO at 4 entries, head granted, new push in the same cycle.
  - Required: fifo_count stays 4; ovf stays 0; the new entry emerges 4 grants later.
- **Zero-vector load/store request.**
  - Stimulus: ls_valid=1, ls_wr_req=0, FIFO empty.
  - Required: ls_ready=1; the next cycle shows buf_wr_req_out=0 and src=1.
- **Reset mid-operation.**
  - Stimulus: assert reset asynchronously while the FIFO holds 3 entries and an output is active.
  - Required: all outputs, fifo_count and ovf read 0 immediately; after release, no stale entries appear.

Source files
------------

// File: rtl/buf_wr_port_arbiter.sv
// rtl/buf_wr_port_arbiter.sv - namespace-buffer write port arbiter (execute FIFO vs load/store)
//
// Ports:
//   clk, reset                   clock, asynchronous active-high reset
//   exec_wr_req/addr/data        execute write push (nonzero req = push), no backpressure
//   ls_valid, ls_ready           load/store handshake (ls_ready is combinational)
//   ls_wr_req/addr/data          load/store write payload
//   clr_ovf                      synchronous clear of the sticky overflow flag
//   buf_wr_req/addr/data_out     registered write port to the buffer banks
//   buf_wr_src                   0 = execute, 1 = load/store
//   fifo_count                   execute FIFO occupancy (0..FIFO_DEPTH)
//   ovf                          sticky execute FIFO overflow
module buf_wr_port_arbiter #(
  parameter int NS_ID_BITS        = 3,
  parameter int NS_INDEX_ID_BITS  = 5,
  parameter int BASE_STRIDE_WIDTH = 4 * (NS_INDEX_ID_BITS + NS_ID_BITS),
  parameter int DATA_WIDTH        = 32,
  parameter int FIFO_DEPTH        = 4,
  parameter int STARVE_LIMIT      = 3
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [5:0]                         exec_wr_req,
  input  logic [BASE_STRIDE_WIDTH-1:0]       exec_wr_addr,
  input  logic [DATA_WIDTH-1:0]              exec_wr_data,
  input  logic                               ls_valid,
  output logic                               ls_ready,
  input  logic [5:0]                         ls_wr_req,
  input  logic [BASE_STRIDE_WIDTH-1:0]       ls_wr_addr,
  input  logic [DATA_WIDTH-1:0]              ls_wr_data,
  input  logic                               clr_ovf,
  output logic [5:0]                         buf_wr_req_out,
  output logic [BASE_STRIDE_WIDTH-1:0]       buf_wr_addr_out,
  output logic [DATA_WIDTH-1:0]              buf_wr_data_out,
  output logic                               buf_wr_src,
  output logic [$clog2(FIFO_DEPTH):0]        fifo_count,
  output logic                               ovf
);

  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int ENTRY_W = 6 + BASE_STRIDE_WIDTH + DATA_WIDTH;

  logic [ENTRY_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count;
  logic [3:0]         starve_cnt;

  logic               fifo_empty;
  logic               fifo_full;
  logic               forced_ls;
  logic               grant_e;
  logic               grant_l;
  logic               push;
  logic               push_ok;
  logic               drop;
  logic [ENTRY_W-1:0] head;

  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == CNT_W'(FIFO_DEPTH));
  assign forced_ls  = (starve_cnt == 4'(STARVE_LIMIT));
  assign head       = mem[rd_ptr];

  // A forced load/store slot blocks the execute head even if load/store
  // has since gone idle; the port simply idles that cycle.
  assign grant_e  = !fifo_empty && !forced_ls;
  // Whenever execute is not granted, ls_ready is high, so grant_l is
  // exactly the handshake.
  assign grant_l  = !grant_e && ls_valid;
  assign ls_ready = fifo_empty || forced_ls;

  // A full FIFO still accepts a push when its head leaves the same cycle.
  assign push    = (exec_wr_req != 6'd0);
  assign push_ok = push && (!fifo_full || grant_e);
  assign drop    = push && fifo_full && !grant_e;

  assign fifo_count = count;

  // Storage is not reset: pointers and count alone define validity.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= {exec_wr_req, exec_wr_addr, exec_wr_data};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (grant_e) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_ok, grant_e})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_cnt <= 4'd0;
    end else if (ls_valid && !ls_ready) begin
      if (starve_cnt != 4'(STARVE_LIMIT)) starve_cnt <= starve_cnt + 4'd1;
    end else begin
      starve_cnt <= 4'd0;
    end
  end

  // Set has priority over clear when both land in the same cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovf <= 1'b0;
    end else if (drop) begin
      ovf <= 1'b1;
    end else if (clr_ovf) begin
      ovf <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      buf_wr_req_out  <= '0;
      buf_wr_addr_out <= '0;
      buf_wr_data_out <= '0;
      buf_wr_src      <= 1'b0;
    end else if (grant_e) begin
      {buf_wr_req_out, buf_wr_addr_out, buf_wr_data_out} <= head;
      buf_wr_src <= 1'b0;
    end else if (grant_l) begin
      buf_wr_src <= 1'b1;
      // A zero-vector request is consumed but drives an idle (all-zero) slot.
      if (ls_wr_req != 6'd0) begin
        buf_wr_req_out  <= ls_wr_req;
        buf_wr_addr_out <= ls_wr_addr;
        buf_wr_data_out <= ls_wr_data;
      end else begin
        buf_wr_req_out  <= '0;
        buf_wr_addr_out <= '0;
        buf_wr_data_out <= '0;
      end
    end else begin
      buf_wr_req_out  <= '0;
      buf_wr_addr_out <= '0;
      buf_wr_data_out <= '0;
    end
  end

endmodule

// File: tb/tb_buf_wr_port_arbiter.sv
// tb/tb_buf_wr_port_arbiter.sv - directed table-driven bench for buf_wr_port_arbiter
module tb_buf_wr_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  exec_wr_req;
  logic [31:0] exec_wr_addr;
  logic [31:0] exec_wr_data;
  logic        ls_valid;
  logic        ls_ready;
  logic [5:0]  ls_wr_req;
  logic [31:0] ls_wr_addr;
  logic [31:0] ls_wr_data;
  logic        clr_ovf;
  logic [5:0]  buf_wr_req_out;
  logic [31:0] buf_wr_addr_out;
  logic [31:0] buf_wr_data_out;
  logic        buf_wr_src;
  logic [2:0]  fifo_count;
  logic        ovf;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  buf_wr_port_arbiter dut (
    .clk             (clk),
    .reset           (reset),
    .exec_wr_req     (exec_wr_req),
    .exec_wr_addr    (exec_wr_addr),
    .exec_wr_data    (exec_wr_data),
    .ls_valid        (ls_valid),
    .ls_ready        (ls_ready),
    .ls_wr_req       (ls_wr_req),
    .ls_wr_addr      (ls_wr_addr),
    .ls_wr_data      (ls_wr_data),
    .clr_ovf         (clr_ovf),
    .buf_wr_req_out  (buf_wr_req_out),
    .buf_wr_addr_out (buf_wr_addr_out),
    .buf_wr_data_out (buf_wr_data_out),
    .buf_wr_src      (buf_wr_src),
    .fifo_count      (fifo_count),
    .ovf             (ovf)
  );

  typedef struct {
    logic [5:0]  e_req;
    logic [31:0] e_addr;
    logic        lv;
    logic [5:0]  l_req;
    logic [31:0] l_addr;
    logic        clr;
    logic        x_rdy;
    logic [5:0]  x_req;
    logic [31:0] x_addr;
    logic        x_src;
    logic [2:0]  x_cnt;
    logic        x_ovf;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic [5:0] er, logic [31:0] ea, logic lv, logic [5:0] lr,
                              logic [31:0] la, logic clr, logic rdy, logic [5:0] xr,
                              logic [31:0] xa, logic xs, logic [2:0] xc, logic xo);
    vec_t v;
    v.e_req = er; v.e_addr = ea; v.lv = lv; v.l_req = lr; v.l_addr = la; v.clr = clr;
    v.x_rdy = rdy; v.x_req = xr; v.x_addr = xa; v.x_src = xs; v.x_cnt = xc; v.x_ovf = xo;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called just after a rising edge: drive, check ls_ready, clock, check outputs.
  task automatic step(input string tag, input vec_t v);
    logic [31:0] xd;
    exec_wr_req  = v.e_req;
    exec_wr_addr = v.e_addr;
    exec_wr_data = 32'hE000_0000 | v.e_addr;
    ls_valid     = v.lv;
    ls_wr_req    = v.l_req;
    ls_wr_addr   = v.l_addr;
    ls_wr_data   = 32'hA000_0000 | v.l_addr;
    clr_ovf      = v.clr;
    #1;
    chk($sformatf("%s ls_ready", tag), 64'(ls_ready), 64'(v.x_rdy));
    @(posedge clk);
    #1;
    if (v.x_req == 6'd0) xd = 32'd0;
    else if (v.x_src)    xd = 32'hA000_0000 | v.x_addr;
    else                 xd = 32'hE000_0000 | v.x_addr;
    chk($sformatf("%s req", tag),   64'(buf_wr_req_out),  64'(v.x_req));
    chk($sformatf("%s addr", tag),  64'(buf_wr_addr_out), 64'(v.x_addr));
    chk($sformatf("%s data", tag),  64'(buf_wr_data_out), 64'(xd));
    chk($sformatf("%s src", tag),   64'(buf_wr_src),      64'(v.x_src));
    chk($sformatf("%s count", tag), 64'(fifo_count),      64'(v.x_cnt));
    chk($sformatf("%s ovf", tag),   64'(ovf),             64'(v.x_ovf));
  endtask

  initial begin
    // Execute-only burst: outputs 0..3 two cycles after each push.
    vecs.push_back(mk(6'h01, 32'h0, 0, 6'h00, 32'h0, 0,  1, 6'h00, 32'h0, 0, 3'd1, 0));
    vecs.push_back(mk(6'h01, 32'h1, 0, 6'h00, 32'h0, 0,  0, 6'h01, 32'h0, 0, 3'd1, 0));
    vecs.push_back(mk(6'h01, 32'h2, 0, 6'h00, 32'h0, 0,  0, 6'h01, 32'h1, 0, 3'd1, 0));
    vecs.push_back(mk(6'h01, 32'h3, 0, 6'h00, 32'h0, 0,  0, 6'h01, 32'h2, 0, 3'd1, 0));
    vecs.push_back(mk(6'h00, 32'h0, 0, 6'h00, 32'h0, 0,  0, 6'h01, 32'h3, 0, 3'd0, 0));
    vecs.push_back(mk(6'h00, 32'h0, 0, 6'h00, 32'h0, 0,  1, 6'h00, 32'h0, 0, 3'd0, 0));
    // Zero-vector load/store request, then a normal one, then idle (src holds).
    vecs.push_back(mk(6'h00, 32'h0, 1, 6'h00, 32'h5, 0,  1, 6'h00, 32'h0, 1, 3'd0, 0));
    vecs.push_back(mk(6'h00, 32'h0, 1, 6'h02, 32'h7, 0,  1, 6'h02, 32'h7, 1, 3'd0, 0));
    vecs.push_back(mk(6'h00, 32'h0, 0, 6'h00, 32'h0, 0,  1, 6'h00, 32'h0, 1, 3'd0, 0));
    // Starvation guard: ls_ready on the 4th cycle of ls_valid, then in-order drain.
    vecs.push_back(mk(6'h04, 32'h10, 0, 6'h20, 32'h40, 0, 1, 6'h00, 32'h0,  1, 3'd1, 0));
    vecs.push_back(mk(6'h04, 32'h11, 1, 6'h20, 32'h40, 0, 0, 6'h04, 32'h10, 0, 3'd1, 0));
    vecs.push_back(mk(6'h04, 32'h12, 1, 6'h20, 32'h40, 0, 0, 6'h04, 32'h11, 0, 3'd1, 0));
    vecs.push_back(mk(6'h04, 32'h13, 1, 6'h20, 32'h40, 0, 0, 6'h04, 32'h12, 0, 3'd1, 0));
    vecs.push_back(mk(6'h04, 32'h14, 1, 6'h20, 32'h40, 0, 1, 6'h20, 32'h40, 1, 3'd2, 0));
    vecs.push_back(mk(6'h04, 32'h15, 0, 6'h20, 32'h40, 0, 0, 6'h04, 32'h13, 0, 3'd2, 0));
    vecs.push_back(mk(6'h00, 32'h0,  0, 6'h00, 32'h0,  0, 0, 6'h04, 32'h14, 0, 3'd1, 0));
    vecs.push_back(mk(6'h00, 32'h0,  0, 6'h00, 32'h0,  0, 0, 6'h04, 32'h15, 0, 3'd0, 0));
    vecs.push_back(mk(6'h00, 32'h0,  0, 6'h00, 32'h0,  0, 1, 6'h00, 32'h0,  0, 3'd0, 0));
    // Fill via forced grants, push+pop at full, overflow, clr_ovf and set-wins.
    vecs.push_back(mk(6'h10, 32'h20, 1, 6'h08, 32'h50, 0, 1, 6'h08, 32'h50, 1, 3'd1, 0));
    vecs.push_back(mk(6'h10, 32'h21, 1, 6'h08, 32'h50, 0, 0, 6'h10, 32'h20, 0, 3'd1, 0));
    vecs.push_back(mk(6'h10, 32'h22, 1, 6'h08, 32'h50, 0, 0, 6'h10, 32'h21, 0, 3'd1, 0));
    vecs.push_back(mk(6'h10, 32'h23, 1, 6'h08, 32'h50, 0, 0, 6'h10, 32'h22, 0, 3'd1, 0));
    vecs.push_back(mk(6'h10, 32'h24, 1, 6'h08, 32'h50, 0, 1, 6'h08, 32'h50, 1, 3'd2, 0));
    vecs.push_back(mk(6'h10, 32'h25, 1, 6'h08, 32'h50, 0, 0, 6'h10, 32'h23, 0, 3'd2, 0));
    vecs.push_back(mk(6'h10, 32'h26, 1, 6'h08, 32'h50, 0, 0, 6'h10, 32'h24, 0, 3'd2, 0));
    vecs.push_back(mk(6'h10, 32'h27, 1, 6'h08, 32'h50, 0, 0, 6'h10, 32'h25, 0, 3'd2, 0));
    vecs.push_back(mk(6'h10, 32'h28, 1, 6'h08, 32'h50, 0, 1, 6'h08, 32'h50, 1, 3'd3, 0));
    vecs.push_back(mk(6'h10, 32'h29, 1, 6'h08, 32'h50, 0, 0, 6'h10, 32'h26, 0, 3'd3, 0));
    vecs.push_back(mk(6'h10, 32'h2A, 1, 6'h08, 32'h50, 0, 0, 6'h10, 32'h27, 0, 3'd3, 0));
    vecs.push_back(mk(6'h10, 32'h2B, 1, 6'h08, 32'h50, 0, 0, 6'h10, 32'h28, 0, 3'd3, 0));
    vecs.push_back(mk(6'h10, 32'h2C, 1, 6'h08, 32'h50, 0, 1, 6'h08, 32'h50, 1, 3'd4, 0));
    vecs.push_back(mk(6'h10, 32'h2D, 1, 6'h08, 32'h50, 0, 0, 6'h10, 32'h29, 0, 3'd4, 0));
    vecs.push_back(mk(6'h10, 32'h2E, 1, 6'h08, 32'h50, 0, 0, 6'h10, 32'h2A, 0, 3'd4, 0));
    vecs.push_back(mk(6'h10, 32'h2F, 1, 6'h08, 32'h50, 0, 0, 6'h10, 32'h2B, 0, 3'd4, 0));
    vecs.push_back(mk(6'h10, 32'h30, 1, 6'h08, 32'h50, 0, 1, 6'h08, 32'h50, 1, 3'd4, 1));
    vecs.push_back(mk(6'h10, 32'h31, 1, 6'h08, 32'h50, 1, 0, 6'h10, 32'h2C, 0, 3'd4, 0));
    vecs.push_back(mk(6'h10, 32'h32, 1, 6'h08, 32'h50, 0, 0, 6'h10, 32'h2D, 0, 3'd4, 0));
    vecs.push_back(mk(6'h10, 32'h33, 1, 6'h08, 32'h50, 0, 0, 6'h10, 32'h2E, 0, 3'd4, 0));
    vecs.push_back(mk(6'h10, 32'h34, 1, 6'h08, 32'h50, 1, 1, 6'h08, 32'h50, 1, 3'd4, 1));
    vecs.push_back(mk(6'h00, 32'h0,  0, 6'h00, 32'h0,  1, 0, 6'h10, 32'h2F, 0, 3'd3, 0));

    reset = 1'b1;
    exec_wr_req = '0; exec_wr_addr = '0; exec_wr_data = '0;
    ls_valid = 1'b0; ls_wr_req = '0; ls_wr_addr = '0; ls_wr_data = '0; clr_ovf = 1'b0;
    #2;
    chk("reset req",   64'(buf_wr_req_out),  64'd0);
    chk("reset src",   64'(buf_wr_src),      64'd0);
    chk("reset count", 64'(fifo_count),      64'd0);
    chk("reset ovf",   64'(ovf),             64'd0);
    chk("reset ready", 64'(ls_ready),        64'd1);
    @(posedge clk);
    #1;
    reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      step($sformatf("row%0d", i), vecs[i]);
    end

    // Asynchronous reset mid-cycle with 3 entries queued and an output active.
    #2;
    exec_wr_req = 6'h3F; exec_wr_addr = 32'h66; exec_wr_data = 32'hE000_0066;
    ls_valid = 1'b1; ls_wr_req = 6'h01; ls_wr_addr = 32'h55; ls_wr_data = 32'hA000_0055;
    reset = 1'b1;
    #1;
    chk("async req",   64'(buf_wr_req_out),  64'd0);
    chk("async addr",  64'(buf_wr_addr_out), 64'd0);
    chk("async data",  64'(buf_wr_data_out), 64'd0);
    chk("async src",   64'(buf_wr_src),      64'd0);
    chk("async count", 64'(fifo_count),      64'd0);
    chk("async ovf",   64'(ovf),             64'd0);
    @(posedge clk);
    #1;
    chk("held req",   64'(buf_wr_req_out), 64'd0);
    chk("held count", 64'(fifo_count),     64'd0);
    exec_wr_req = '0; ls_valid = 1'b0; ls_wr_req = '0;
    reset = 1'b0;

    step("post0", mk(6'h00, 32'h0,  0, 6'h00, 32'h0, 0, 1, 6'h00, 32'h0,  0, 3'd0, 0));
    step("post1", mk(6'h00, 32'h0,  0, 6'h00, 32'h0, 0, 1, 6'h00, 32'h0,  0, 3'd0, 0));
    step("post2", mk(6'h3F, 32'h77, 0, 6'h00, 32'h0, 0, 1, 6'h00, 32'h0,  0, 3'd1, 0));
    step("post3", mk(6'h00, 32'h0,  0, 6'h00, 32'h0, 0, 0, 6'h3F, 32'h77, 0, 3'd0, 0));
    step("post4", mk(6'h00, 32'h0,  0, 6'h00, 32'h0, 0, 1, 6'h00, 32'h0,  0, 3'd0, 0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
